// File: rtl/nios2_jtag_host_pkg.sv
// nios2_jtag_host_pkg: shared types, widths and timing helper for the JTAG debug host driver
package nios2_jtag_host_pkg;
    localparam int JTAG_SR_WIDTH = 38;
    localparam int JTAG_IR_WIDTH = 2;

    typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RSP} state_t;

    // clks from the accepting edge to rsp_valid: UIR + CDR + SR_WIDTH shifts + UDR periods
    function automatic int rsp_latency(input int sr_width, input int tck_half);
        return (sr_width + 3) * 2 * tck_half;
    endfunction
endpackage

// File: rtl/nios2_jtag_debug_host_driver_if.sv
// nios2_jtag_debug_host_driver_if: command/response handshake between agent and driver
interface nios2_jtag_debug_host_driver_if
    import nios2_jtag_host_pkg::*;
#(
    parameter int SR_WIDTH = JTAG_SR_WIDTH,
    parameter int IR_WIDTH = JTAG_IR_WIDTH
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [SR_WIDTH-1:0] cmd_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [SR_WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_ir, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/nios2_jtag_host_tck_gen.sv
// nios2_jtag_host_tck_gen: divided tck with one-clk pulses marking the clk before each tck edge
module nios2_jtag_host_tck_gen #(
    parameter int TCK_HALF = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tck,
    output logic rise_pulse,
    output logic fall_pulse
);
    localparam logic [7:0] LAST = 8'(TCK_HALF - 1);

    logic [7:0] cnt;
    logic       wrap;

    assign wrap       = run && cnt == LAST;
    assign rise_pulse = wrap && !tck;
    assign fall_pulse = wrap && tck;

    always_ff @(posedge clk) begin
        if (!reset_n || !run) begin
            cnt <= '0;
            tck <= 1'b0;
        end else begin
            cnt <= cnt == LAST ? '0 : cnt + 8'd1;
            tck <= tck ^ (cnt == LAST);
        end
    end
endmodule

// File: rtl/nios2_jtag_debug_host_driver.sv
// nios2_jtag_debug_host_driver: turns an IR + scan word command into a virtual-JTAG uir/cdr/sdr/udr
// sequence and returns the captured tdo word
module nios2_jtag_debug_host_driver
    import nios2_jtag_host_pkg::*;
#(
    parameter int SR_WIDTH = JTAG_SR_WIDTH,
    parameter int IR_WIDTH = JTAG_IR_WIDTH,
    parameter int TCK_HALF = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    nios2_jtag_debug_host_driver_if.slave bus,
    output logic                          vji_tck,
    output logic                          vji_tdi,
    input  logic                          vji_tdo,
    output logic [IR_WIDTH-1:0]           vji_ir_in,
    output logic                          vji_rti,
    output logic                          vji_uir,
    output logic                          vji_cdr,
    output logic                          vji_sdr,
    output logic                          vji_udr
);
    localparam int CW = $clog2(SR_WIDTH);

    state_t              state;
    logic [SR_WIDTH-1:0] tx;
    logic [SR_WIDTH-1:0] rx;
    logic [CW-1:0]       bit_cnt;
    logic                run;
    logic                rise_pulse;
    logic                fall_pulse;

    assign run = state != IDLE && state != RSP;

    nios2_jtag_host_tck_gen #(.TCK_HALF(TCK_HALF)) u_tck_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .tck        (vji_tck),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    // all state, strobe and tdi changes land on fall_pulse so each is stable over one tck rise
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            tx            <= '0;
            rx            <= '0;
            bit_cnt       <= '0;
            vji_tdi       <= 1'b0;
            vji_ir_in     <= '0;
            vji_rti       <= 1'b1;
            vji_uir       <= 1'b0;
            vji_cdr       <= 1'b0;
            vji_sdr       <= 1'b0;
            vji_udr       <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    state         <= UIR;
                    vji_ir_in     <= bus.cmd_ir;
                    tx            <= bus.cmd_data;
                    rx            <= '0;
                    bit_cnt       <= '0;
                    vji_rti       <= 1'b0;
                    vji_uir       <= 1'b1;
                    bus.cmd_ready <= 1'b0;
                end
                UIR: if (fall_pulse) begin
                    state   <= CDR;
                    vji_uir <= 1'b0;
                    vji_cdr <= 1'b1;
                end
                CDR: if (fall_pulse) begin
                    state   <= SDR;
                    vji_cdr <= 1'b0;
                    vji_sdr <= 1'b1;
                    vji_tdi <= tx[0];
                end
                SDR: begin
                    if (rise_pulse) rx <= {vji_tdo, rx[SR_WIDTH-1:1]};
                    if (fall_pulse) begin
                        tx      <= tx >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        vji_tdi <= bit_cnt == CW'(SR_WIDTH - 1) ? 1'b0 : tx[1];
                        if (bit_cnt == CW'(SR_WIDTH - 1)) begin
                            state   <= UDR;
                            vji_sdr <= 1'b0;
                            vji_udr <= 1'b1;
                        end
                    end
                end
                UDR: if (fall_pulse) begin
                    state         <= RSP;
                    vji_udr       <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_data  <= rx;
                end
                RSP: if (bus.rsp_ready) begin
                    state         <= IDLE;
                    vji_rti       <= 1'b1;
                    bus.rsp_valid <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nios2_jtag_debug_host_driver.sv
// tb_nios2_jtag_debug_host_driver: scoreboard bench for the JTAG debug host driver (TCK_HALF 2 and 1 builds)
module tb_nios2_jtag_debug_host_driver;
    import nios2_jtag_host_pkg::*;

    localparam int SW = JTAG_SR_WIDTH;
    localparam int IW = JTAG_IR_WIDTH;
    localparam logic [SW-1:0] PRE = 38'h3F_FFFF_0001;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    nios2_jtag_debug_host_driver_if #(.SR_WIDTH(SW), .IR_WIDTH(IW)) bus0 ();
    nios2_jtag_debug_host_driver_if #(.SR_WIDTH(SW), .IR_WIDTH(IW)) bus1 ();

    logic          tck0, tdi0, tdo0, rti0, uir0, cdr0, sdr0, udr0;
    logic [IW-1:0] ir0;
    logic          tck1, tdi1, tdo1, rti1, uir1, cdr1, sdr1, udr1;
    logic [IW-1:0] ir1;

    nios2_jtag_debug_host_driver #(.TCK_HALF(2)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus0),
        .vji_tck(tck0), .vji_tdi(tdi0), .vji_tdo(tdo0), .vji_ir_in(ir0), .vji_rti(rti0),
        .vji_uir(uir0), .vji_cdr(cdr0), .vji_sdr(sdr0), .vji_udr(udr0)
    );

    nios2_jtag_debug_host_driver #(.TCK_HALF(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1),
        .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdo1), .vji_ir_in(ir1), .vji_rti(rti1),
        .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1)
    );

    int checks = 0;
    int errors = 0;
    logic [SW-1:0] q0[$];
    logic [SW-1:0] q1[$];
    logic [SW-1:0] e0, e1;

    // tdo sources: mode 0 = tdi delayed one tck period, mode 1 = responder register loaded at cdr
    logic          mode;
    logic [3:0]    hist = '0;
    logic [SW-1:0] rresp = '0;
    logic          tck_q = 1'b0;
    int n_uir, n_cdr, n_sdr, n_udr, sdr_rises;

    assign tdo0 = mode ? rresp[0] : hist[3];

    always @(posedge clk) begin
        hist  <= {hist[2:0], tdi0};
        tck_q <= tck0;
        if (cdr0) rresp <= PRE;
        else if (sdr0 && tck0 && !tck_q) rresp <= rresp >> 1;
        if (bus0.cmd_valid && bus0.cmd_ready) begin
            n_uir     <= 0;
            n_cdr     <= 0;
            n_sdr     <= 0;
            n_udr     <= 0;
            sdr_rises <= 0;
        end else begin
            n_uir     <= n_uir + int'(uir0);
            n_cdr     <= n_cdr + int'(cdr0);
            n_sdr     <= n_sdr + int'(sdr0);
            n_udr     <= n_udr + int'(udr0);
            sdr_rises <= sdr_rises + int'(sdr0 && tck0 && !tck_q);
        end
    end

    always @(negedge clk) begin
        if (bus0.rsp_valid && bus0.rsp_ready) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL rsp0_unexpected actual=%h required=no response", bus0.rsp_data);
            end else begin
                e0 = q0.pop_front();
                if (bus0.rsp_data !== e0) begin
                    errors++;
                    $display("FAIL rsp0_data actual=%h required=%h", bus0.rsp_data, e0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus1.rsp_valid && bus1.rsp_ready) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL rsp1_unexpected actual=%h required=no response", bus1.rsp_data);
            end else begin
                e1 = q1.pop_front();
                if (bus1.rsp_data !== e1) begin
                    errors++;
                    $display("FAIL rsp1_data actual=%h required=%h", bus1.rsp_data, e1);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_cmd_ready"}, bus0.cmd_ready, 1);
        chk({tag, "_rsp_valid"}, bus0.rsp_valid, 0);
        chk({tag, "_rsp_data"}, bus0.rsp_data, 0);
        chk({tag, "_tck_tdi_ir"}, {tck0, tdi0, ir0}, 0);
        chk({tag, "_rti"}, rti0, 1);
        chk({tag, "_strobes"}, {uir0, cdr0, sdr0, udr0}, 0);
    endtask

    task automatic issue(input logic [IW-1:0] ir, input logic [SW-1:0] d, input logic [SW-1:0] exp, input bit push);
        chk("accept_ready", bus0.cmd_ready, 1);
        bus0.cmd_ir    = ir;
        bus0.cmd_data  = d;
        bus0.cmd_valid = 1'b1;
        if (push) q0.push_back(exp);
        @(posedge clk); #1;
        bus0.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus0.rsp_valid && n < 2 * rsp_latency(SW, 2)) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_seen", bus0.rsp_valid, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus0.cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("back_to_idle", bus0.cmd_ready, 1);
    endtask

    task automatic run1(input logic [IW-1:0] ir, input logic [SW-1:0] exp);
        int n;
        chk("u1_accept_ready", bus1.cmd_ready, 1);
        bus1.cmd_ir    = ir;
        bus1.cmd_data  = 38'h2A_0000_5555;
        bus1.cmd_valid = 1'b1;
        q1.push_back(exp);
        @(posedge clk); #1;
        bus1.cmd_valid = 1'b0;
        chk("u1_ir_on_accept", ir1, ir);
        n = 0;
        while (!bus1.rsp_valid && n < 2 * rsp_latency(SW, 1)) begin
            @(posedge clk); #1;
            n++;
        end
        chk("u1_latency", n, 82);
        n = 0;
        while (!bus1.cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("u1_idle", bus1.cmd_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int cnt;
        bit ok_v, ok_d, ok_r, ok_t;
        logic [SW-1:0] held;
        reset_n        = 1'b0;
        mode           = 1'b0;
        tdo1           = 1'b1;
        bus0.cmd_valid = 1'b0;
        bus0.cmd_ir    = '0;
        bus0.cmd_data  = '0;
        bus0.rsp_ready = 1'b1;
        bus1.cmd_valid = 1'b0;
        bus1.cmd_ir    = '0;
        bus1.cmd_data  = '0;
        bus1.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_rst("por");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // loopback with one-period delay
        issue(2'b01, 38'h2A_5555_AAAA, 38'h14_AAAB_5554, 1);
        chk("rti_drops", rti0, 0);
        wait_rsp(lat);
        chk("latency", lat, 164);
        chk("uir_clks", n_uir, 4);
        chk("cdr_clks", n_cdr, 4);
        chk("sdr_clks", n_sdr, 152);
        chk("udr_clks", n_udr, 4);
        wait_idle();
        chk("ir_holds", ir0, 2'b01);
        chk("rti_back", rti0, 1);

        // responder preloaded at cdr
        mode = 1'b1;
        issue(2'b00, '0, PRE, 1);
        wait_rsp(lat);
        chk("sdr_tck_rises", sdr_rises, 38);
        wait_idle();

        // backpressure
        bus0.rsp_ready = 1'b0;
        issue(2'b11, 38'h15, PRE, 1);
        wait_rsp(lat);
        held = bus0.rsp_data;
        {ok_v, ok_d, ok_r, ok_t} = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ok_v &= bus0.rsp_valid;
            ok_d &= bus0.rsp_data === held;
            ok_r &= !bus0.cmd_ready;
            ok_t &= !tck0;
        end
        chk("bp_valid_stable", ok_v, 1);
        chk("bp_data_stable", ok_d, 1);
        chk("bp_cmd_ready_low", ok_r, 1);
        chk("bp_tck_low", ok_t, 1);
        @(posedge clk); #1;
        bus0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", bus0.rsp_valid, 0);
        chk("bp_release_ready", bus0.cmd_ready, 1);

        // command offered while busy is ignored
        mode = 1'b0;
        issue(2'b11, 38'h3, 38'h6, 1);
        cnt = 0;
        while (n_sdr < 40 && cnt < 1000) begin
            @(posedge clk); #1;
            cnt++;
        end
        bus0.cmd_ir    = 2'b10;
        bus0.cmd_data  = 38'h3F_FFFF_FFFF;
        bus0.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus0.cmd_valid = 1'b0;
        chk("busy_ir_unchanged", ir0, 2'b11);
        chk("busy_cmd_ready", bus0.cmd_ready, 0);
        wait_rsp(lat);
        wait_idle();
        issue(2'b10, 38'h10_0000_0001, 38'h20_0000_0002, 1);
        chk("reoffer_ir", ir0, 2'b10);
        wait_rsp(lat);
        wait_idle();

        // reset mid-SDR at bit 17
        issue(2'b01, 38'h3F_0F0F_0F0F, '0, 0);
        cnt = 0;
        while (sdr_rises < 18 && cnt < 1000) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("abort_reached_bit17", sdr_rises, 18);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk_rst("abort");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready_after_release", bus0.cmd_ready, 1);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            cnt += int'(bus0.rsp_valid);
        end
        chk("abort_no_rsp", cnt, 0);

        // TCK_HALF=1 build, back-to-back
        run1(2'b01, 38'h3F_FFFF_FFFF);
        chk("u1_ir_holds", ir1, 2'b01);
        tdo1 = 1'b0;
        run1(2'b10, '0);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nios2_jtag_debug_host_driver.md
Name: nios2_jtag_debug_host_driver

Overview:
Host-side initiator for the Nios II JTAG debug module's virtual-JTAG interface.
Turns a command (IR value plus 38-bit scan word) into the uir/cdr/sdr/udr strobe sequence, a divided tck and serial tdi.
Captures tdo into a 38-bit response.
Used in system-level benches and in on-chip self-test, where a soft agent drives the debug module's tck/sysclk logic without a physical JTAG cable.

Parameters:
SR_WIDTH, 38, scan data width; matches the debug module shift register.
IR_WIDTH, 2, virtual IR width.
TCK_HALF, 2, clk cycles per tck half-period; legal values are 1 to 255.

Ports:
clk  in  1  system clock.
reset_n  in  1  synchronous active-low reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  driver idle and able to accept a command.
cmd_ir  in  IR_WIDTH  IR value for the transaction.
cmd_data  in  SR_WIDTH  word to shift in, LSB first.
rsp_valid  out  1  response available.
rsp_ready  in  1  response consumed.
rsp_data  out  SR_WIDTH  captured tdo word; the first bit shifted out lands in bit 0.
vji_tck  out  1  generated test clock.
vji_tdi  out  1  serial data to the responder.
vji_tdo  in  1  serial data from the responder.
vji_ir_in  out  IR_WIDTH  current virtual IR.
vji_rti  out  1  run-test-idle indication.
vji_uir  out  1  update-IR strobe.
vji_cdr  out  1  capture-DR strobe.
vji_sdr  out  1  shift-DR strobe.
vji_udr  out  1  update-DR strobe.

Behaviour:
- Clocking and reset: one clock (clk); reset_n is synchronous and active-low.
- Reset values: state IDLE; vji_tck=0, vji_tdi=0, vji_ir_in=0, vji_rti=1, all strobes 0, cmd_ready=1, rsp_valid=0, rsp_data=0.
- tck generation: tck is produced only outside IDLE/RSP. It is low for TCK_HALF clks, then high for TCK_HALF clks.
  - rise_pulse marks the clk on which tck goes 0->1.
  - fall_pulse marks the clk on which tck goes 1->0.
  - One tck period is P = 2*TCK_HALF clks.
- States:
  - IDLE: rti=1, cmd_ready=1. Accept when cmd_valid and cmd_ready.
    - On accept: latch cmd_ir into vji_ir_in, latch cmd_data into the tx shift register, clear the bit counter, go to UIR.
    - rti drops on the same edge.
  - UIR: uir=1 for exactly one tck period, then CDR.
  - CDR: cdr=1 for one period, then SDR.
  - SDR: sdr=1 for exactly SR_WIDTH periods.
    - vji_tdi = tx[0] for the whole period.
    - On rise_pulse: rx <= {vji_tdo, rx[SR_WIDTH-1:1]}.
    - On fall_pulse: tx >>= 1 and counter++.
    - At counter = SR_WIDTH-1 on fall_pulse, go to UDR.
  - UDR: udr=1 for one period. At its end: rsp_data <= rx, rsp_valid=1, tck stays 0, go to RSP.
  - RSP: hold rsp_valid and rsp_data until rsp_ready=1. Then rsp_valid=0 on the next edge and go to IDLE (rti=1, cmd_ready=1).
- Strobe timing: every state transition and tdi change occurs on a fall_pulse edge, so each strobe is stable across exactly one tck rising edge.
- Latency: rsp_valid rises exactly (SR_WIDTH+3)*P clks after the accepting edge; with defaults that is 164.
- vji_tdi returns to 0 outside SDR.
- vji_ir_in holds its value after the transaction until the next accept.
- cmd_valid while busy: ignored, cmd_ready=0, no latching.
- rsp_ready while rsp_valid=0: no effect.
- A command cannot be accepted in the same cycle as the response handshake, because cmd_ready only rises in IDLE.
- Reset mid-operation, in any state: on the next edge, all reset values apply, the partial rx is discarded and no response is produced.
- tdo is sampled only on rise_pulse in SDR. tdo in other states is ignored.

Decomposition:
- Shared package nios2_jtag_host_pkg:
  - state enum {IDLE, UIR, CDR, SDR, UDR, RSP}
  - constants JTAG_SR_WIDTH=38, JTAG_IR_WIDTH=2
  - cycle-count function for (SR_WIDTH+3)*P, used by the bench
- Sub-module nios2_jtag_host_tck_gen:
  - inputs: clk, reset_n, run
  - outputs: tck, rise_pulse, fall_pulse
  - owns the TCK_HALF counter
  - tck is forced to 0 and the counter cleared whenever run=0

Test Plan:
- Reset check: assert reset_n=0 for 3 clks mid-SDR (counter=17) -> on the next edge, all outputs at reset values; cmd_ready=1 one cycle after release; no rsp_valid ever asserted for the aborted command.
- Loopback: tie tdo to the tdi delayed by one period. Send cmd_ir=2'b01, cmd_data=38'h2A_5555_AAAA -> uir, cdr, sdr and udr each seen for 4, 4, 152 and 4 clks; rsp_valid at clk 164; rsp_data = cmd_data shifted by the delay, checked bit-exact.
- Responder model: drive tdo from a 38-bit register preloaded with 38'h3F_FFFF_0001 at cdr. Send cmd_data=0 -> rsp_data=38'h3F_FFFF_0001; exactly 38 tck rising edges with sdr=1.
- Backpressure: hold rsp_ready=0 for 20 clks -> rsp_valid and rsp_data stable, cmd_ready=0 throughout, tck constant 0. Raise rsp_ready -> rsp_valid=0 and cmd_ready=1 on the next edge.
- Busy command: pulse cmd_valid with cmd_ir=2'b10 during SDR -> ignored; vji_ir_in unchanged; after the response completes, a re-offered command is accepted.
- TCK_HALF=1 build: two back-to-back commands -> P=2, rsp_valid at clk 82 after each accept; vji_ir_in updates only on accept edges.
